// File: rtl/capture_readout.sv
// capture_readout: drains the circular capture buffer oldest-first onto a valid/ready byte stream.
// Define CAPTURE_READOUT_HEADER_EN to prefix each non-empty readout with a 4-byte header.
module capture_readout #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 8,
  parameter int RAM_DEPTH = 262144
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(RAM_DEPTH);
  localparam logic [ADDR_W:0]   ZERO_LEN  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   ONE_LEN   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

`ifdef CAPTURE_READOUT_HEADER_EN
  typedef enum logic [2:0] {IDLE = 3'd0, READ = 3'd1, LATCH = 3'd2, SEND = 3'd3,
                            FIN = 3'd4, HDR = 3'd5} state_t;
  localparam state_t FIRST_ST = HDR;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, READ = 3'd1, LATCH = 3'd2, SEND = 3'd3,
                            FIN = 3'd4} state_t;
  localparam state_t FIRST_ST = READ;
`endif

  state_t              state_r, next_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [ADDR_W:0]     remaining_r;
  logic                ram_en_r, ram_en_d;
  logic [ADDR_W-1:0]   ram_addr_r, ram_addr_d;
  logic [DATA_W-1:0]   m_data_r, m_data_d;
  logic                m_valid_r, m_valid_d;
  logic                busy_r, busy_d, done_r, done_d, err_r, err_d;
  logic                fire_s, start_bad_s, start_go_s;

  assign fire_s      = m_valid_r & m_ready;
  assign start_bad_s = ({1'b0, base_addr} >= DEPTH_L) || (length > DEPTH_L);
  assign start_go_s  = start & ~abort & ~start_bad_s;

`ifdef CAPTURE_READOUT_HEADER_EN
  logic [1:0]      hdr_idx_r, hdr_idx_d;
  logic [ADDR_W:0] hdr_len_s;

  // Header byte for a given index: marker, then length little-endian (top byte 3 bits wide)
  function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [ADDR_W:0] len);
    case (idx)
      2'd0:    hdr_byte = 8'hA5;
      2'd1:    hdr_byte = 8'(len);
      2'd2:    hdr_byte = 8'(len >> 8);
      2'd3:    hdr_byte = 8'(len >> 16) & 8'h07;
      default: hdr_byte = 8'hA5;
    endcase
  endfunction

  // Next header index and the length the header describes
  always_comb begin
    if (state_r == IDLE) begin
      hdr_idx_d = 2'd0;
      hdr_len_s = length;
    end else if (state_r == HDR && fire_s) begin
      hdr_idx_d = hdr_idx_r + 2'd1;
      hdr_len_s = remaining_r;
    end else begin
      hdr_idx_d = hdr_idx_r;
      hdr_len_s = remaining_r;
    end
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state_r <= IDLE;
    else         state_r <= next_s;
  end

  // Next-state logic; abort overrides everything outside IDLE
  always_comb begin
    next_s = state_r;
    if (state_r != IDLE && abort) begin
      next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (start_go_s) next_s = (length == ZERO_LEN) ? FIN : FIRST_ST;
          else            next_s = IDLE;
        end
        READ:  next_s = LATCH;
        LATCH: next_s = SEND;
        SEND: begin
          if (fire_s) next_s = (remaining_r == ONE_LEN) ? FIN : READ;
          else        next_s = SEND;
        end
        FIN:   next_s = IDLE;
`ifdef CAPTURE_READOUT_HEADER_EN
        HDR: begin
          if (fire_s && hdr_idx_r == 2'd3) next_s = READ;
          else                             next_s = HDR;
        end
`endif
        default: next_s = IDLE;
      endcase
    end
  end

  // Output values for the next cycle, derived from the upcoming state so outputs stay registered
  always_comb begin
    ram_en_d = (next_s == READ);
    if (next_s == READ) ram_addr_d = (state_r == IDLE) ? base_addr : addr_r;
    else                ram_addr_d = ram_addr_r;
`ifdef CAPTURE_READOUT_HEADER_EN
    m_valid_d = (next_s == SEND) || (next_s == HDR);
    if (state_r == LATCH && next_s == SEND) m_data_d = ram_dout;
    else if (next_s == HDR)                 m_data_d = DATA_W'(hdr_byte(hdr_idx_d, hdr_len_s));
    else                                    m_data_d = m_data_r;
`else
    m_valid_d = (next_s == SEND);
    if (state_r == LATCH && next_s == SEND) m_data_d = ram_dout;
    else                                    m_data_d = m_data_r;
`endif
    busy_d = (next_s != IDLE);
    done_d = (next_s == FIN);
    err_d  = (state_r == IDLE) && start && !abort && start_bad_s;
  end

  // Address/count datapath and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_r      <= ZERO_ADDR;
      remaining_r <= ZERO_LEN;
      ram_en_r    <= 1'b0;
      ram_addr_r  <= ZERO_ADDR;
      m_data_r    <= {DATA_W{1'b0}};
      m_valid_r   <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
`ifdef CAPTURE_READOUT_HEADER_EN
      hdr_idx_r   <= 2'd0;
`endif
    end else begin
      if (state_r == IDLE && start_go_s) begin
        addr_r      <= base_addr;
        remaining_r <= length;
      end else if (state_r == READ && !abort) begin
        // Compare-based wrap so non-power-of-two depths work
        addr_r <= (addr_r == LAST_ADDR) ? ZERO_ADDR : addr_r + ONE_ADDR;
      end else if (state_r == SEND && fire_s && !abort) begin
        remaining_r <= remaining_r - ONE_LEN;
      end
      ram_en_r   <= ram_en_d;
      ram_addr_r <= ram_addr_d;
      m_data_r   <= m_data_d;
      m_valid_r  <= m_valid_d;
      busy_r     <= busy_d;
      done_r     <= done_d;
      err_r      <= err_d;
`ifdef CAPTURE_READOUT_HEADER_EN
      hdr_idx_r  <= hdr_idx_d;
`endif
    end
  end

  assign ram_en   = ram_en_r;
  assign ram_addr = ram_addr_r;
  assign m_data   = m_data_r;
  assign m_valid  = m_valid_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_capture_readout.sv
// Self-checking bench for capture_readout: queue-based readout model plus directed literal checks.
// Built with a 20-entry buffer behind a 5-bit address so wrap must be compare-based.
module tb_capture_readout;

  localparam int AW = 5;
  localparam int D  = 20;
`ifdef CAPTURE_READOUT_HEADER_EN
  localparam int HOFF = 4;
`else
  localparam int HOFF = 0;
`endif

  logic          clk, resetn, start, abort, m_ready;
  logic [AW-1:0] base_addr, ram_addr;
  logic [AW:0]   length;
  logic          ram_en, m_valid, busy, done, err;
  logic [7:0]    ram_dout, m_data;
  logic [7:0]    mem [0:31];

  capture_readout #(.ADDR_W(AW), .DATA_W(8), .RAM_DEPTH(D)) dut (
    .clk(clk), .resetn(resetn), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length), .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_dout(ram_dout), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done), .err(err));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read RAM
  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Behavioural model state
  typedef enum {M_IDLE, M_ACT, M_FIN} mst_t;
  mst_t       mstate = M_IDLE;
  logic [7:0] bq[$];
  int         aq[$];
  logic [7:0] beat_log[$];
  int         addr_log[$];
  int         hdr_left = 0, cyc_since = 0, m_cur;
  bit         err_due = 0, hold_prev = 0, m_acc, chk_en = 0;
  logic [7:0] data_prev;
  logic [31:0] len32;
  int         done_cnt = 0, ramen_cnt = 0, valid_cnt = 0;
  int         ready_mode = 0, stall_cnt = 0;

  always @(negedge clk) begin
    m_cur = cyc_since + 1;
    if (chk_en) begin
      check("busy", busy, mstate != M_IDLE);
      check("done", done, mstate == M_FIN);
      check("err", err, err_due);
      if (mstate == M_ACT && hdr_left == 0) check("m_valid_timing", m_valid, m_cur >= 3);
      else if (mstate != M_ACT)             check("m_valid_idle", m_valid, 1'b0);
      check("ram_en", ram_en, mstate == M_ACT && hdr_left == 0 && m_cur == 1);
      if (hold_prev) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", m_data, data_prev);
      end
      if (ram_en) begin
        ramen_cnt++;
        addr_log.push_back(int'(ram_addr));
        if (aq.size() == 0) check("extra_ram_en", 1'b1, 1'b0);
        else                check("ram_addr", ram_addr, aq.pop_front());
      end
      if (m_valid) valid_cnt++;
      if (done) done_cnt++;
    end
    err_due = 0; hold_prev = 0; m_acc = 0;
    if (!resetn) begin
      mstate = M_IDLE; bq.delete(); aq.delete(); hdr_left = 0;
    end else begin
      case (mstate)
        M_IDLE: if (start && !abort) begin
          if (int'(base_addr) >= D || int'(length) > D) err_due = 1;
          else if (length == 0) mstate = M_FIN;
          else begin
`ifdef CAPTURE_READOUT_HEADER_EN
            len32 = 32'(length);
            bq.push_back(8'hA5); bq.push_back(len32[7:0]);
            bq.push_back(len32[15:8]); bq.push_back({5'b00000, len32[18:16]});
            hdr_left = 4;
`endif
            for (int k = 0; k < int'(length); k++) begin
              bq.push_back(mem[(int'(base_addr) + k) % D]);
              aq.push_back((int'(base_addr) + k) % D);
            end
            mstate = M_ACT; m_acc = 1;
          end
        end
        M_ACT: begin
          if (abort) begin
            mstate = M_IDLE; bq.delete(); aq.delete(); hdr_left = 0;
          end else if (m_valid && m_ready) begin
            beat_log.push_back(m_data);
            if (bq.size() == 0) check("extra_beat", 1'b1, 1'b0);
            else                check("beat_data", m_data, bq.pop_front());
            if (hdr_left > 0) hdr_left--;
            m_acc = 1;
            if (bq.size() == 0) mstate = M_FIN;
          end else begin
            if (m_valid) begin hold_prev = 1; data_prev = m_data; end
            if (m_cur > 300) begin
              check("watchdog", 1'b0, 1'b1);
              mstate = M_IDLE; bq.delete(); aq.delete(); hdr_left = 0;
            end
          end
        end
        default: mstate = M_IDLE;
      endcase
    end
    cyc_since = m_acc ? 0 : m_cur;
  end

  // Sink ready: always, random, or a 7-cycle stall on the second sample
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: begin m_ready = 1'b1; stall_cnt = 0; end
        1: begin m_ready = ($urandom_range(0, 3) != 0); stall_cnt = 0; end
        default: begin
          m_ready = !(beat_log.size() == HOFF + 1 && stall_cnt < 7);
          if (!m_ready && m_valid) stall_cnt++;
        end
      endcase
    end
  end

  task automatic clear_logs();
    beat_log.delete(); addr_log.delete();
    done_cnt = 0; ramen_cnt = 0; valid_cnt = 0;
  endtask

  task automatic do_start(input int b, input int l);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(b); length = (AW+1)'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (mstate == M_IDLE && busy == 1'b0) begin ok = 1; break; end
    end
    check(name, ok, 1'b1);
    @(posedge clk); #1;
  endtask

  int exp_w [5] = '{18, 19, 0, 1, 2};
  bit seen [0:D-1];
  int uniq;

  initial begin
    resetn = 1'b0; start = 1'b0; abort = 1'b0; base_addr = '0; length = '0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_en", ram_en, 1'b0);   check("rst_ram_addr", ram_addr, 0);
    check("rst_m_data", m_data, 0);      check("rst_m_valid", m_valid, 1'b0);
    check("rst_busy", busy, 1'b0);       check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    resetn = 1'b1; chk_en = 1;

    // Basic readout: samples 5..14
    clear_logs(); do_start(5, 10); wait_done("t1_timeout");
    check("t1_beats", beat_log.size(), HOFF + 10);
    if (beat_log.size() >= HOFF + 10)
      for (int k = 0; k < 10; k++) check("t1_sample", beat_log[HOFF + k], 8'(5 + k));
`ifdef CAPTURE_READOUT_HEADER_EN
    if (beat_log.size() >= 4) begin
      check("t1_hdr0", beat_log[0], 8'hA5); check("t1_hdr1", beat_log[1], 8'h0A);
      check("t1_hdr2", beat_log[2], 8'h00); check("t1_hdr3", beat_log[3], 8'h00);
    end
`endif
    check("t1_done_cnt", done_cnt, 1);
    check("t1_ram_en_cnt", ramen_cnt, 10);

    // Wrap at a non-power-of-two depth
    clear_logs(); do_start(18, 5); wait_done("t2_timeout");
    check("t2_addr_cnt", addr_log.size(), 5);
    if (addr_log.size() >= 5)
      for (int k = 0; k < 5; k++) check("t2_addr_seq", addr_log[k], exp_w[k]);

    // Backpressure on the second sample
    clear_logs(); ready_mode = 2; do_start(0, 10); wait_done("t3_timeout");
    check("t3_stall_cycles", stall_cnt, 7);
    ready_mode = 0;
    check("t3_beats", beat_log.size(), HOFF + 10);
    check("t3_ram_en_cnt", ramen_cnt, 10);

    // Zero length and rejected starts
    clear_logs(); do_start(3, 0);
    check("t4_done_pulse", done, 1'b1);
    @(posedge clk); #1;
    check("t4_done_low", done, 1'b0); check("t4_busy_low", busy, 1'b0);
    check("t4_no_valid", valid_cnt, 0);
    do_start(D, 4);
    check("t4_err_base", err, 1'b1); check("t4_err_busy", busy, 1'b0);
    @(posedge clk); #1;
    check("t4_err_low", err, 1'b0);
    do_start(0, D + 1);
    check("t4_err_len", err, 1'b1);
    @(posedge clk); #1;

    // Abort during the 4th sample SEND, then a fresh readout
    clear_logs(); do_start(0, 10);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (m_valid && beat_log.size() == HOFF + 3) begin abort = 1'b1; break; end
    end
    @(posedge clk); #1;
    abort = 1'b0;
    check("t5_valid_after_abort", m_valid, 1'b0);
    check("t5_busy_after_abort", busy, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("t5_no_done", done_cnt, 0);
    check("t5_beats", beat_log.size(), HOFF + 3);
    clear_logs(); do_start(2, 4); wait_done("t5_timeout");
    check("t5_new_beats", beat_log.size(), HOFF + 4);
    if (beat_log.size() >= HOFF + 4)
      for (int k = 0; k < 4; k++) check("t5_new_sample", beat_log[HOFF + k], 8'(2 + k));

    // Full-depth readout: each location once
    clear_logs(); do_start(7, D); wait_done("t6_timeout");
    for (int i = 0; i < D; i++) seen[i] = 0;
    uniq = 0;
    foreach (addr_log[i])
      if (addr_log[i] < D && !seen[addr_log[i]]) begin seen[addr_log[i]] = 1; uniq++; end
    check("t6_unique_addrs", uniq, D);
    check("t6_ram_en_cnt", ramen_cnt, D);

    // Reset in the middle of a readout
    clear_logs(); do_start(3, 10);
    repeat (8) @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    check("t7_valid", m_valid, 1'b0);   check("t7_busy", busy, 1'b0);
    check("t7_ram_en", ram_en, 1'b0);   check("t7_ram_addr", ram_addr, 0);
    check("t7_m_data", m_data, 0);

    // Randomized traffic: starts (also while busy), aborts, random backpressure
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    clear_logs(); ready_mode = 1;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      start     = ($urandom_range(0, 7) == 0);
      abort     = ($urandom_range(0, 99) == 0);
      base_addr = AW'($urandom_range(0, 23));
      length    = (AW+1)'($urandom_range(0, 23));
    end
    start = 1'b0; abort = 1'b0; ready_mode = 0;
    wait_done("rnd_timeout");
    check("rnd_some_done", done_cnt > 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
